// File: rtl/ui_pkg.sv
// Shared front-panel definitions: button channel indices, default repeat mask
// and the per-channel auto-repeat state encoding.
package ui_pkg;

  localparam int BTN_MODE      = 0;
  localparam int BTN_DIGIT_CHG = 1;
  localparam int BTN_DIGIT_INC = 2;
  localparam int BTN_RST_DIGIT = 3;
  localparam int BTN_RST_VALUE = 4;

  localparam int DEFAULT_NUM_BUTTONS = 5;

  // Only the digit-increment button steps repeatedly while held.
  localparam logic [DEFAULT_NUM_BUTTONS-1:0] REPEAT_MASK_DEFAULT = 5'b00100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, stable-count debouncer and optional
// auto-repeat FSM producing single-cycle press/repeat pulses.
module button_channel
  import ui_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic             RAW_IDLE   = ACTIVE_LOW;
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic             sync_a;
  logic             sync_b;
  logic             pressed;
  logic [DB_W-1:0]  db_cnt;
  logic             accept;
  logic             rise;
  logic             fall;
  rep_state_e       state;
  rep_state_e       state_next;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_next;
  logic             rep_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= RAW_IDLE;
      sync_b <= RAW_IDLE;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  assign pressed = ACTIVE_LOW ? ~sync_b : sync_b;
  assign accept  = (pressed != level) && (db_cnt == DB_LAST);
  assign rise    = accept && pressed;
  assign fall    = accept && !pressed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      if (pressed == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        level  <= pressed;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      pulse <= rise || rep_fire;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rep_cnt <= '0;
    end else begin
      state   <= state_next;
      rep_cnt <= rep_cnt_next;
    end
  end

  // A release landing on the same edge as a due repeat wins: no pulse.
  always_comb begin
    state_next   = state;
    rep_cnt_next = rep_cnt;
    rep_fire     = 1'b0;
    if (!REPEAT_EN || fall) begin
      state_next   = IDLE;
      rep_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          rep_cnt_next = '0;
          if (rise) state_next = HOLD;
        end
        HOLD: begin
          if (rep_cnt == DELAY_LAST) begin
            rep_fire     = 1'b1;
            rep_cnt_next = '0;
            state_next   = REPEAT;
          end else begin
            rep_cnt_next = rep_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rep_cnt == RATE_LAST) begin
            rep_fire     = 1'b1;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt + 1'b1;
          end
        end
        default: begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel button front end: one independent conditioning channel per
// button, each with its own polarity handling and auto-repeat enable.
module button_conditioner
  import ui_pkg::*;
#(
  parameter int                     NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
  parameter bit                     ACTIVE_LOW      = 1'b1,
  parameter int                     DEBOUNCE_CYCLES = 4,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = REPEAT_MASK_DEFAULT,
  parameter int                     REPEAT_DELAY    = 16,
  parameter int                     REPEAT_RATE     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_pulse
);

  // No arbitration: simultaneous presses yield simultaneous pulses.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_MASK[i]),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end for the front-panel push buttons (mode select, digit change, digit increment, reset digit, reset value).
- Converts raw, asynchronous, bouncing button levels into clean debounced levels and single-cycle press pulses.
- The pulses feed the edit-mode selector and the register/instruction editors directly.
- Optional auto-repeat per channel, so a held increment button steps repeatedly.

Parameters:
NUM_BUTTONS, 5, number of independent button channels
ACTIVE_LOW, 1, 1 = raw input reads 0 when pressed; 0 = raw reads 1 when pressed
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change; legal range >= 2
REPEAT_MASK, 5'b00100, per-channel auto-repeat enable (bit i enables channel i)
REPEAT_DELAY, 16, cycles from press pulse to first repeat pulse; legal range >= 1
REPEAT_RATE, 8, cycles between subsequent repeat pulses; legal range >= 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_raw  input  NUM_BUTTONS  raw button pins, asynchronous to clk, polarity per ACTIVE_LOW
btn_level  output  NUM_BUTTONS  debounced logical level; 1 = pressed
btn_pulse  output  NUM_BUTTONS  one-cycle pulse on accepted press and on each auto-repeat

Behaviour:
- One clock (clk); reset is asynchronous and active-high. All flops clear on reset assertion, regardless of clk.
- Reset values:
  - btn_level = 0, btn_pulse = 0.
  - Synchronizer flops hold the not-pressed raw level (1 if ACTIVE_LOW, else 0).
  - All counters = 0.
- Each channel is independent and identical.
- Synchronizer: two-flop chain on btn_raw[i], then polarity normalised so that 1 = pressed (sync_i).
- Debounce:
  - cnt increments each cycle sync_i != btn_level[i]; cnt clears to 0 on any cycle sync_i == btn_level[i].
  - When cnt == DEBOUNCE_CYCLES-1 and sync_i still differs: btn_level[i] <= sync_i and cnt <= 0.
  - Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no output change.
  - Counter width is $clog2(DEBOUNCE_CYCLES). No wrap is possible.
- Press latency: raw pressed level stable and first sampled at edge k -> btn_level and btn_pulse become 1 after edge k+DEBOUNCE_CYCLES+1.
- Release latency is identical. A release produces no pulse.
- Press pulse: btn_pulse[i] is 1 for exactly the one cycle following the edge where btn_level[i] goes 0->1.
- Auto-repeat (REPEAT_MASK[i]=1 only), state machine per channel:
  - IDLE: btn_level=0. Enter HOLD on the press edge with rep_cnt=0.
  - HOLD: rep_cnt counts up. At rep_cnt == REPEAT_DELAY-1, emit a pulse, rep_cnt <= 0, go to REPEAT.
  - REPEAT: at rep_cnt == REPEAT_RATE-1, emit a pulse, rep_cnt <= 0, stay in REPEAT.
  - From any state, btn_level going 0 -> IDLE, rep_cnt <= 0, and no further pulses from the release edge onward.
- Result: first repeat pulse follows the press pulse by REPEAT_DELAY cycles; later pulses are spaced REPEAT_RATE cycles apart.
- rep_cnt width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
- Channels with REPEAT_MASK[i]=0 never leave IDLE semantics: one pulse per press.
- Simultaneous presses on several channels give simultaneous pulses. There is no priority or arbitration; downstream handles it.
- Reset mid-debounce or mid-repeat:
  - Everything clears immediately.
  - After reset release, a still-held button is re-debounced from scratch and produces a fresh press pulse.

Decomposition:
- Shared package (ui_pkg) holds:
  - button index constants BTN_MODE=0, BTN_DIGIT_CHG=1, BTN_DIGIT_INC=2, BTN_RST_DIGIT=3, BTN_RST_VALUE=4;
  - default REPEAT_MASK;
  - the repeat-state enum (IDLE, HOLD, REPEAT).
- One sub-module, button_channel: synchronizer, debounce counter and repeat FSM for a single bit.
- The top level generates NUM_BUTTONS instances and applies ACTIVE_LOW and REPEAT_MASK per instance.

Test Plan:
- Reset then idle, raw all 1 (ACTIVE_LOW): btn_level=0, btn_pulse=0 for 100 cycles. Assert reset mid-run: outputs 0 without waiting for a clk edge.
- Clean press on ch0, raw[0]=0 held 50 cycles, DEBOUNCE_CYCLES=4: btn_level[0]=1 and btn_pulse[0]=1 for one cycle, 5 edges after first sample. No repeat pulses (mask bit 0).
- Bounce on ch1: 0/1 toggle every 2 cycles for 20 cycles, then held 0: no pulse during bounce; exactly one pulse, 5 edges after the toggling stops. Release with 3-cycle glitches: level stays 1 until the release has been stable 4 synced cycles.
- Auto-repeat ch2 held 60 cycles after press pulse at cycle P: pulses at P, P+16, P+24, P+32, P+40, P+48, P+56. Release: btn_level falls after debounce; no pulse thereafter.
- Simultaneous press of ch0 and ch4 on the same cycle: both pulses on the same cycle; each channel's btn_level is independent of the other.
- Reset asserted at HOLD cycle 10 with ch2 still pressed, released 3 cycles later: no stale repeat pulse; a fresh press pulse occurs 5 edges after reset release, and repeat timing restarts from it.
